// File: rtl/digit_bbox_locator.sv
// digit_bbox_locator
// Tracks the bounding box and ink-pixel count of a digit inside a fixed
// recognition window. One result is published per frame at the vsync active
// edge, and the outputs then hold until the next publish.
module digit_bbox_locator #(
    parameter logic [10:0] ROI_X0    = 11'd390,
    parameter logic [10:0] ROI_X1    = 11'd890,
    parameter logic [9:0]  ROI_Y0    = 10'd110,
    parameter logic [9:0]  ROI_Y1    = 10'd610,
    parameter logic [17:0] MIN_PIX   = 18'd64,
    parameter logic        VSYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_vsync,
    input  logic        i_vde,
    input  logic        i_bit,
    input  logic [10:0] i_setx,
    input  logic [9:0]  i_sety,
    output logic [10:0] o_x_min,
    output logic [10:0] o_x_max,
    output logic [9:0]  o_y_min,
    output logic [9:0]  o_y_max,
    output logic [17:0] o_pix_cnt,
    output logic        o_found,
    output logic        o_valid
);

    typedef enum logic [0:0] {
        S_DISARMED = 1'b0,
        S_ACCUM    = 1'b1
    } state_t;

    localparam logic [17:0] CNT_MAX = 18'h3FFFF;

    state_t      state_q, state_d;
    logic        vs_q;
    logic [10:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [9:0]  ymin_q, ymin_d, ymax_q, ymax_d;
    logic [17:0] cnt_q, cnt_d;
    logic [10:0] ox_min_q, ox_min_d, ox_max_q, ox_max_d;
    logic [9:0]  oy_min_q, oy_min_d, oy_max_q, oy_max_d;
    logic [17:0] ocnt_q, ocnt_d;
    logic        found_q, found_d;
    logic        valid_q, valid_d;

    logic        edge_s;
    logic        qual_s;

    // Edge is the first cycle vsync reaches its active level; border pixels never qualify.
    always_comb begin
        edge_s = (i_vsync == VSYNC_POL) && (vs_q != VSYNC_POL);
        qual_s = i_vde && i_bit &&
                 (i_setx > ROI_X0) && (i_setx < ROI_X1) &&
                 (i_sety > ROI_Y0) && (i_sety < ROI_Y1);
    end

    // Next-state: arm on the first edge, then publish-and-clear on every edge and accumulate in between.
    always_comb begin
        state_d  = state_q;
        xmin_d   = xmin_q;
        xmax_d   = xmax_q;
        ymin_d   = ymin_q;
        ymax_d   = ymax_q;
        cnt_d    = cnt_q;
        ox_min_d = ox_min_q;
        ox_max_d = ox_max_q;
        oy_min_d = oy_min_q;
        oy_max_d = oy_max_q;
        ocnt_d   = ocnt_q;
        found_d  = found_q;
        valid_d  = 1'b0;
        case (state_q)
            S_DISARMED: begin
                if (edge_s) begin
                    state_d = S_ACCUM;
                    xmin_d  = 11'h7FF;
                    xmax_d  = 11'd0;
                    ymin_d  = 10'h3FF;
                    ymax_d  = 10'd0;
                    cnt_d   = 18'd0;
                end else begin
                    state_d = S_DISARMED;
                end
            end
            S_ACCUM: begin
                if (edge_s) begin
                    // A pixel arriving in the edge cycle is dropped with the clear.
                    valid_d = 1'b1;
                    ocnt_d  = cnt_q;
                    if (cnt_q >= MIN_PIX) begin
                        found_d  = 1'b1;
                        ox_min_d = xmin_q;
                        ox_max_d = xmax_q;
                        oy_min_d = ymin_q;
                        oy_max_d = ymax_q;
                    end else begin
                        found_d  = 1'b0;
                        ox_min_d = 11'd0;
                        ox_max_d = 11'd0;
                        oy_min_d = 10'd0;
                        oy_max_d = 10'd0;
                    end
                    xmin_d = 11'h7FF;
                    xmax_d = 11'd0;
                    ymin_d = 10'h3FF;
                    ymax_d = 10'd0;
                    cnt_d  = 18'd0;
                end else if (qual_s) begin
                    if (i_setx < xmin_q) begin
                        xmin_d = i_setx;
                    end else begin
                        xmin_d = xmin_q;
                    end
                    if (i_setx > xmax_q) begin
                        xmax_d = i_setx;
                    end else begin
                        xmax_d = xmax_q;
                    end
                    if (i_sety < ymin_q) begin
                        ymin_d = i_sety;
                    end else begin
                        ymin_d = ymin_q;
                    end
                    if (i_sety > ymax_q) begin
                        ymax_d = i_sety;
                    end else begin
                        ymax_d = ymax_q;
                    end
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 18'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    state_d = S_ACCUM;
                end
            end
            default: begin
                state_d = S_DISARMED;
                xmin_d  = 11'h7FF;
                xmax_d  = 11'd0;
                ymin_d  = 10'h3FF;
                ymax_d  = 10'd0;
                cnt_d   = 18'd0;
            end
        endcase
    end

    // State, vsync history, accumulators and published results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_DISARMED;
            vs_q     <= VSYNC_POL;   // a vsync already active at reset release is not an edge
            xmin_q   <= 11'h7FF;
            xmax_q   <= 11'd0;
            ymin_q   <= 10'h3FF;
            ymax_q   <= 10'd0;
            cnt_q    <= 18'd0;
            ox_min_q <= 11'd0;
            ox_max_q <= 11'd0;
            oy_min_q <= 10'd0;
            oy_max_q <= 10'd0;
            ocnt_q   <= 18'd0;
            found_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            vs_q     <= i_vsync;
            xmin_q   <= xmin_d;
            xmax_q   <= xmax_d;
            ymin_q   <= ymin_d;
            ymax_q   <= ymax_d;
            cnt_q    <= cnt_d;
            ox_min_q <= ox_min_d;
            ox_max_q <= ox_max_d;
            oy_min_q <= oy_min_d;
            oy_max_q <= oy_max_d;
            ocnt_q   <= ocnt_d;
            found_q  <= found_d;
            valid_q  <= valid_d;
        end
    end

    assign o_x_min   = ox_min_q;
    assign o_x_max   = ox_max_q;
    assign o_y_min   = oy_min_q;
    assign o_y_max   = oy_max_q;
    assign o_pix_cnt = ocnt_q;
    assign o_found   = found_q;
    assign o_valid   = valid_q;

endmodule

// File: tb/tb_digit_bbox_locator.sv
// Testbench for digit_bbox_locator: a scoreboard of expected publishes is
// filled when each vsync edge is driven and drained by a monitor that sees
// o_valid. Two instances cover active-high and active-low vsync.
module tb_digit_bbox_locator;

    typedef struct {
        logic [10:0] xmin;
        logic [10:0] xmax;
        logic [9:0]  ymin;
        logic [9:0]  ymax;
        logic [17:0] cnt;
        logic        found;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vs1 = 1'b0;
    logic        vs0 = 1'b1;
    logic        i_vde = 1'b0;
    logic        i_bit = 1'b0;
    logic [10:0] i_setx = 11'd0;
    logic [9:0]  i_sety = 10'd0;

    logic [10:0] x_min1, x_max1, x_min0, x_max0;
    logic [9:0]  y_min1, y_max1, y_min0, y_max0;
    logic [17:0] cnt1, cnt0;
    logic        found1, found0, valid1, valid0;

    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    exp_t q1[$];
    exp_t q0[$];

    digit_bbox_locator dut1 (
        .clk(clk), .rst(rst), .i_vsync(vs1), .i_vde(i_vde), .i_bit(i_bit),
        .i_setx(i_setx), .i_sety(i_sety),
        .o_x_min(x_min1), .o_x_max(x_max1), .o_y_min(y_min1), .o_y_max(y_max1),
        .o_pix_cnt(cnt1), .o_found(found1), .o_valid(valid1)
    );

    digit_bbox_locator #(.VSYNC_POL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .i_vsync(vs0), .i_vde(i_vde), .i_bit(i_bit),
        .i_setx(i_setx), .i_sety(i_sety),
        .o_x_min(x_min0), .o_x_max(x_max0), .o_y_min(y_min0), .o_y_max(y_max0),
        .o_pix_cnt(cnt0), .o_found(found0), .o_valid(valid0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every o_valid pulse must match the oldest expected publish, in the expected cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid1) begin
                checks = checks + 1;
                if (q1.size() == 0) begin
                    $display("FAIL pol1_unexpected_valid: got o_valid=1 at cycle %0d, required no publish", cyc);
                end else begin
                    passed = passed + 1;
                    e = q1.pop_front();
                    checks = checks + 1;
                    if ({x_min1, x_max1, y_min1, y_max1, cnt1, found1} !==
                        {e.xmin, e.xmax, e.ymin, e.ymax, e.cnt, e.found}) begin
                        $display("FAIL pol1_result: got x=%0d..%0d y=%0d..%0d cnt=%0d found=%0b, required x=%0d..%0d y=%0d..%0d cnt=%0d found=%0b",
                                 x_min1, x_max1, y_min1, y_max1, cnt1, found1,
                                 e.xmin, e.xmax, e.ymin, e.ymax, e.cnt, e.found);
                    end else begin
                        passed = passed + 1;
                    end
                    checks = checks + 1;
                    if (cyc !== e.cyc) begin
                        $display("FAIL pol1_latency: got valid at cycle %0d, required %0d", cyc, e.cyc);
                    end else begin
                        passed = passed + 1;
                    end
                end
            end
            if (valid0) begin
                checks = checks + 1;
                if (q0.size() == 0) begin
                    $display("FAIL pol0_unexpected_valid: got o_valid=1 at cycle %0d, required no publish", cyc);
                end else begin
                    passed = passed + 1;
                    e = q0.pop_front();
                    checks = checks + 1;
                    if ({x_min0, x_max0, y_min0, y_max0, cnt0, found0} !==
                        {e.xmin, e.xmax, e.ymin, e.ymax, e.cnt, e.found}) begin
                        $display("FAIL pol0_result: got x=%0d..%0d y=%0d..%0d cnt=%0d found=%0b, required x=%0d..%0d y=%0d..%0d cnt=%0d found=%0b",
                                 x_min0, x_max0, y_min0, y_max0, cnt0, found0,
                                 e.xmin, e.xmax, e.ymin, e.ymax, e.cnt, e.found);
                    end else begin
                        passed = passed + 1;
                    end
                    checks = checks + 1;
                    if (cyc !== e.cyc) begin
                        $display("FAIL pol0_latency: got valid at cycle %0d, required %0d", cyc, e.cyc);
                    end else begin
                        passed = passed + 1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y, input logic b, input logic v);
        step();
        i_setx = 11'(x);
        i_sety = 10'(y);
        i_bit  = b;
        i_vde  = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            i_bit = 1'b0;
            i_vde = 1'b0;
        end
    endtask

    task automatic drive_block(input int x0, input int y0, input int w, input int h, input logic v);
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                set_pix(x0 + xx, y0 + yy, 1'b1, v);
            end
        end
        idle(1);
    endtask

    function automatic exp_t mk(input int xa, input int xb, input int ya, input int yb,
                                input int c, input logic f);
        exp_t e;
        e.xmin = 11'(xa); e.xmax = 11'(xb);
        e.ymin = 10'(ya); e.ymax = 10'(yb);
        e.cnt = 18'(c); e.found = f; e.cyc = 0;
        return e;
    endfunction

    // Active-high vsync edge on dut1; pushes the expected publish when one is due.
    task automatic edge1(input logic pub, input exp_t e);
        exp_t t;
        step();
        vs1 = 1'b1;
        i_bit = 1'b0;
        i_vde = 1'b0;
        if (pub) begin
            t = e;
            t.cyc = cyc + 1;
            q1.push_back(t);
        end
        idle(3);
        vs1 = 1'b0;
        idle(3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks = checks + 1;
        if ({x_min1, x_max1, y_min1, y_max1, cnt1, found1, valid1} !== 61'd0) begin
            $display("FAIL reset_outputs: got %h, required 0", {x_min1, x_max1, y_min1, y_max1, cnt1, found1, valid1});
        end else begin
            passed = passed + 1;
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_first_frame();
        drive_block(500, 300, 20, 20, 1'b1);
        edge1(1'b0, mk(0, 0, 0, 0, 0, 1'b0));
        drive_block(500, 300, 20, 20, 1'b1);
        edge1(1'b1, mk(500, 519, 300, 319, 400, 1'b1));
    endtask

    task automatic test_borders();
        set_pix(390, 300, 1'b1, 1'b1);
        set_pix(890, 300, 1'b1, 1'b1);
        set_pix(500, 110, 1'b1, 1'b1);
        set_pix(500, 610, 1'b1, 1'b1);
        drive_block(600, 400, 10, 10, 1'b1);
        checks = checks + 1;
        if (cnt1 !== 18'd400 || x_min1 !== 11'd500) begin
            $display("FAIL hold_between_publishes: got cnt=%0d x_min=%0d, required cnt=400 x_min=500", cnt1, x_min1);
        end else begin
            passed = passed + 1;
        end
        edge1(1'b1, mk(600, 609, 400, 409, 100, 1'b1));
    endtask

    task automatic test_sparse();
        for (int i = 0; i < 30; i++) begin
            set_pix(400 + i * 10, 120 + i * 10, 1'b1, 1'b1);
            set_pix(401 + i * 10, 120 + i * 10, 1'b0, 1'b1);
        end
        edge1(1'b1, mk(0, 0, 0, 0, 30, 1'b0));
    endtask

    task automatic test_vde_off();
        drive_block(450, 200, 10, 8, 1'b1);
        edge1(1'b1, mk(450, 459, 200, 207, 80, 1'b1));
        drive_block(500, 300, 20, 20, 1'b0);
        edge1(1'b1, mk(0, 0, 0, 0, 0, 1'b0));
    endtask

    task automatic test_mid_reset();
        drive_block(700, 500, 10, 10, 1'b1);
        edge1(1'b1, mk(700, 709, 500, 509, 100, 1'b1));
        drive_block(500, 300, 20, 10, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_block(500, 310, 20, 10, 1'b1);
        edge1(1'b0, mk(0, 0, 0, 0, 0, 1'b0));
        checks = checks + 1;
        if ({x_min1, x_max1, y_min1, y_max1, cnt1, found1} !== 60'd0) begin
            $display("FAIL mid_reset_outputs: got x=%0d..%0d y=%0d..%0d cnt=%0d found=%0b, required all 0",
                     x_min1, x_max1, y_min1, y_max1, cnt1, found1);
        end else begin
            passed = passed + 1;
        end
        drive_block(420, 130, 10, 10, 1'b1);
        edge1(1'b1, mk(420, 429, 130, 139, 100, 1'b1));
    endtask

    // Active-low build: long vsync hold gives one pulse; the edge-cycle pixel joins neither frame.
    task automatic test_vsync_low();
        exp_t t;
        step();
        vs0 = 1'b0;
        idle(3);
        vs0 = 1'b1;
        idle(3);
        drive_block(600, 400, 10, 10, 1'b1);
        step();
        vs0 = 1'b0;
        i_setx = 11'd700;
        i_sety = 10'd500;
        i_bit = 1'b1;
        i_vde = 1'b1;
        t = mk(600, 609, 400, 409, 100, 1'b1);
        t.cyc = cyc + 1;
        q0.push_back(t);
        idle(50);
        vs0 = 1'b1;
        idle(2);
        for (int i = 0; i < 70; i++) begin
            set_pix(601 + i, 450, 1'b1, 1'b1);
        end
        step();
        vs0 = 1'b0;
        i_bit = 1'b0;
        i_vde = 1'b0;
        t = mk(601, 670, 450, 450, 70, 1'b1);
        t.cyc = cyc + 1;
        q0.push_back(t);
        idle(5);
        vs0 = 1'b1;
        idle(3);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_borders();
        test_sparse();
        test_vde_off();
        test_mid_reset();
        test_vsync_low();
        idle(5);
        checks = checks + 1;
        if (q1.size() != 0 || q0.size() != 0) begin
            $display("FAIL missing_publish: got %0d/%0d pending expectations, required 0/0", q1.size(), q0.size());
        end else begin
            passed = passed + 1;
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/digit_bbox_locator.md
Name: digit_bbox_locator

Overview:
- Pixel-stream stage fed by the binarisation stage (1 bit/pixel, 1 = ink/foreground) and its pixel coordinates.
- Tracks the bounding box and ink-pixel count of the handwritten digit inside the fixed recognition window (ROI) over one frame.
- Publishes the results once per frame, at the vsync active edge, to the downstream digit-identification stage.
- Results are held stable for the whole following frame, so the identifier can segment against them.

Parameters:
- ROI_X0, 390, left ROI border (exclusive); pixel counts only if x > ROI_X0
- ROI_X1, 890, right ROI border (exclusive); pixel counts only if x < ROI_X1
- ROI_Y0, 110, top ROI border (exclusive)
- ROI_Y1, 610, bottom ROI border (exclusive)
- MIN_PIX, 64, minimum ink-pixel count for a frame to report o_found=1
- VSYNC_POL, 1, active level of i_vsync (1 = active-high)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- i_vsync  in  1  frame sync, polarity per VSYNC_POL
- i_vde  in  1  active-video qualifier
- i_bit  in  1  binarised pixel, 1 = ink
- i_setx  in  11  pixel column, aligned with i_bit
- i_sety  in  10  pixel row, aligned with i_bit
- o_x_min  out  11  leftmost ink column of last completed frame
- o_x_max  out  11  rightmost ink column
- o_y_min  out  10  topmost ink row
- o_y_max  out  10  bottommost ink row
- o_pix_cnt  out  18  ink pixels counted in ROI, saturating at 2^18-1
- o_found  out  1  1 = o_pix_cnt >= MIN_PIX for last frame
- o_valid  out  1  one-cycle pulse when outputs update

Behaviour:
- Reset: all outputs 0; o_valid 0; state DISARMED; accumulators initialised as in the clear rule below.
- Reset asserted mid-frame: the partial frame is discarded and nothing is published.
- Vsync edge detect:
  - i_vsync is registered (vs_q).
  - Edge cycle E is the cycle in which i_vsync == VSYNC_POL and vs_q != VSYNC_POL.
- State machine:
  - DISARMED: no accumulation. At E -> ACCUM, accumulators cleared, nothing published. This discards the partial first frame after reset.
  - ACCUM: qualifies and accumulates pixels. At E -> ACCUM (self loop): publish the current frame, then clear the accumulators.
- Qualified pixel: i_vde=1 AND i_bit=1 AND ROI_X0<i_setx<ROI_X1 AND ROI_Y0<i_sety<ROI_Y1. Pixels on ROI borders never count.
- Accumulate, per qualified pixel:
  - xmin=min(xmin,x), xmax=max(xmax,x), ymin=min(ymin,y), ymax=max(ymax,y).
  - cnt+=1, saturating at 262143 with no wrap.
- Clear values: xmin=11'h7FF, xmax=0, ymin=10'h3FF, ymax=0, cnt=0.
- Publish, registered at the clock edge ending cycle E; outputs visible and o_valid=1 in cycle E+1 only:
  - If cnt >= MIN_PIX: o_found=1 and the bbox outputs take the accumulator values.
  - Else: o_found=0 and all four bbox outputs =0. o_pix_cnt=cnt in both cases.
- The accumulator clear takes effect at the same edge. A qualified pixel in cycle E is dropped; it belongs to neither frame.
- Outputs hold unchanged between publishes.
- No publish while i_vsync is held active; a second edge requires vsync to deassert first.
- Latency: frame result available 1 cycle after the vsync active edge is sampled.
- Widths: comparisons are unsigned. i_setx/i_sety are used directly, with no offset subtraction; the downstream stage works in screen coordinates.

Test Plan:
- Reset, then drive a frame with an ink block x=500..519, y=300..319 (400 px), then a vsync edge -> no o_valid (DISARMED); the same frame again -> o_valid once, x_min=500, x_max=519, y_min=300, y_max=319, pix_cnt=400, found=1.
- Armed; ink on x=390, x=890, y=110, y=610 only, plus a 10x10 block at (600,400) -> pix_cnt=100, bbox=600..609 / 400..409 (borders excluded).
- Armed; 30 scattered ink pixels (cnt < MIN_PIX=64) -> o_valid pulse, found=0, all bbox=0, pix_cnt=30.
- Armed; ink with i_vde=0 across the whole frame -> pix_cnt=0, found=0. An empty frame following a full one resets the outputs to 0 (no stale hold).
- Armed; assert rst for 1 cycle mid-frame after 200 ink px, continue the frame -> no o_valid at the next edge, outputs 0. The following full frame publishes normally.
- VSYNC_POL=0 build, vsync held active for 50 cycles -> exactly one o_valid pulse, 1 cycle after the falling edge. An ink pixel coinciding with the edge cycle is not counted in either frame.
